// File: rtl/text_banner_renderer.sv
// Scaled 4x6-font text banner overlay with typewriter reveal and blink.
// Optional drop shadow enabled by defining TEXT_SHADOW_EN.
module text_banner_renderer #(
  parameter int NUM_CHARS    = 17,
  parameter int SCALE_LOG2   = 3,
  parameter int CHAR_PITCH   = 36,
  parameter int ORIGIN_X     = 16,
  parameter int ORIGIN_Y     = 40,
  parameter int TYPE_FRAMES  = 9,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_tick,
  input  logic [9:0]             pix_x,
  input  logic [9:0]             pix_y,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [5*NUM_CHARS-1:0] msg,
  input  logic [5:0]             fg_rgb,
  output logic                   text_on,
  output logic [1:0]             r,
  output logic [1:0]             g,
  output logic [1:0]             b,
  output logic                   done,
  output logic                   busy
);

  localparam int LW = $clog2(NUM_CHARS + 1);
  localparam logic [9:0] GW = 10'(4 << SCALE_LOG2);
  localparam logic [9:0] GH = 10'(6 << SCALE_LOG2);
  localparam logic [LW-1:0] NC = LW'(NUM_CHARS);
  localparam logic [LW-1:0] NC1 = LW'(NUM_CHARS - 1);
  localparam logic [7:0] TF1 = 8'(TYPE_FRAMES - 1);
  localparam logic [7:0] BF1 = 8'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TYPING,
    S_SHOW
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LW-1:0]          r_char_limit;
  logic [7:0]             r_type_cnt;
  logic [7:0]             r_blink_cnt;
  logic                   r_blink_phase;
  logic [5*NUM_CHARS-1:0] r_msg;
  logic [1:0]             r_mode;
  logic                   r_done;
  logic                   r_text_on;
  logic [5:0]             r_rgb;
  logic                   w_char_step;
  logic                   w_done_set;
  logic                   w_blink;
  logic                   w_vis;
  logic                   w_text;
  logic [5:0]             w_rgb;

  function automatic logic [23:0] f_glyph(input logic [4:0] c);
    case (c)
      5'd1:    return 24'h699F99;
      5'd2:    return 24'hE9E99E;
      5'd3:    return 24'hE8888E;
      5'd4:    return 24'hE9999E;
      5'd5:    return 24'hF8E88F;
      5'd6:    return 24'hF8E888;
      5'd7:    return 24'h78B997;
      5'd8:    return 24'h99F999;
      5'd9:    return 24'hE4444E;
      5'd10:   return 24'h111196;
      5'd11:   return 24'h9ACA99;
      5'd12:   return 24'h88888F;
      5'd13:   return 24'h9FF999;
      5'd14:   return 24'h9DFB99;
      5'd15:   return 24'h699996;
      5'd16:   return 24'hE99E88;
      5'd17:   return 24'h6999B7;
      5'd18:   return 24'hE99EA9;
      5'd19:   return 24'h78611E;
      5'd20:   return 24'hE44444;
      5'd21:   return 24'h999996;
      5'd22:   return 24'h999966;
      5'd23:   return 24'h999FF9;
      5'd24:   return 24'h996699;
      5'd25:   return 24'h996444;
      5'd26:   return 24'hF1248F;
      5'd27:   return 24'h124421;
      5'd28:   return 24'h842248;
      5'd29:   return 24'h00F000;
      5'd30:   return 24'h444404;
      5'd31:   return 24'h040040;
      default: return 24'h000000;
    endcase
  endfunction

  // Pitch >= glyph width, so at most one character box can match.
  function automatic logic f_lit(
    input logic [9:0]             x,
    input logic [9:0]             y,
    input logic [LW-1:0]          lim,
    input logic [5*NUM_CHARS-1:0] m
  );
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [4:0]  idx;
    logic [23:0] sh;
    logic        hit;
    hit = 1'b0;
    dy  = y - 10'(ORIGIN_Y);
    for (int k = 0; k < NUM_CHARS; k++) begin
      dx  = x - 10'(ORIGIN_X + k * CHAR_PITCH);
      idx = {3'(dy >> SCALE_LOG2), 2'b00}
          + {3'b000, 2'(dx >> SCALE_LOG2)};
      sh  = f_glyph(m[5*k +: 5]) << idx;
      if (dy < GH && dx < GW && LW'(k) < lim && sh[23])
        hit = 1'b1;
    end
    return hit;
  endfunction

  assign w_char_step = frame_tick && (r_type_cnt == TF1);
  assign w_blink     = (r_mode == 2'd2) || (r_mode == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start)
      w_state_nxt = (mode == 2'd1 || mode == 2'd3) ? S_TYPING : S_SHOW;
    else if (r_state == S_TYPING && w_char_step && r_char_limit == NC1)
      w_state_nxt = S_SHOW;
  end

  always_comb begin
    busy       = (r_state == S_TYPING);
    w_done_set = (w_state_nxt == S_SHOW)
              && (start || r_state == S_TYPING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_char_limit  <= '0;
      r_type_cnt    <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
      r_msg         <= '0;
      r_mode        <= '0;
      r_done        <= 1'b0;
    end else begin
      r_done <= w_done_set;
      if (start) begin
        r_msg         <= msg;
        r_mode        <= mode;
        r_type_cnt    <= '0;
        r_blink_cnt   <= '0;
        r_blink_phase <= 1'b1;
        r_char_limit  <= (w_state_nxt == S_TYPING) ? '0 : NC;
      end else if (frame_tick) begin
        case (r_state)
          S_TYPING: begin
            if (w_char_step) begin
              r_type_cnt   <= '0;
              r_char_limit <= r_char_limit + 1'b1;
              if (r_char_limit == NC1) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b1;
              end
            end else begin
              r_type_cnt <= r_type_cnt + 8'd1;
            end
          end
          S_SHOW: begin
            if (w_blink) begin
              if (r_blink_cnt == BF1) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
              end else begin
                r_blink_cnt <= r_blink_cnt + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign w_vis  = w_blink ? r_blink_phase : 1'b1;
  assign w_text = w_vis && f_lit(pix_x, pix_y, r_char_limit, r_msg);

`ifdef TEXT_SHADOW_EN
  localparam logic [9:0] SH = 10'(1 << SCALE_LOG2);
  logic w_shadow;
  assign w_shadow = w_vis && !w_text
    && f_lit(pix_x - SH, pix_y - SH, r_char_limit, r_msg);
  assign w_rgb = w_text ? fg_rgb : (w_shadow ? 6'b010101 : 6'b0);
`else
  assign w_rgb = w_text ? fg_rgb : 6'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_text_on <= 1'b0;
      r_rgb     <= '0;
    end else begin
      r_text_on <= w_text;
      r_rgb     <= w_rgb;
    end
  end

  assign text_on = r_text_on;
  assign r       = r_rgb[5:4];
  assign g       = r_rgb[3:2];
  assign b       = r_rgb[1:0];
  assign done    = r_done;

endmodule

// File: tb/tb_text_banner_renderer.sv
// Scoreboard bench for text_banner_renderer: random stimulus against a
// frame-count reference model of reveal, blink and glyph lookup.
module tb_text_banner_renderer;

  localparam int N  = 17;
  localparam int S  = 3;
  localparam int P  = 36;
  localparam int OX = 16;
  localparam int OY = 40;
  localparam int TF = 9;
  localparam int BF = 32;
  localparam int GW = 4 << S;
  localparam int GH = 6 << S;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           frame_tick = 1'b0;
  logic [9:0]     pix_x = '0;
  logic [9:0]     pix_y = '0;
  logic           start = 1'b0;
  logic [1:0]     mode = '0;
  logic [5*N-1:0] msg = '0;
  logic [5:0]     fg_rgb = '0;
  logic           text_on;
  logic [1:0]     r, g, b;
  logic           done;
  logic           busy;

  text_banner_renderer #(
    .NUM_CHARS(N), .SCALE_LOG2(S), .CHAR_PITCH(P),
    .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .TYPE_FRAMES(TF), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .pix_x(pix_x), .pix_y(pix_y), .start(start), .mode(mode),
    .msg(msg), .fg_rgb(fg_rgb), .text_on(text_on),
    .r(r), .g(g), .b(b), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [23:0] font [0:31] = '{
    24'h000000, 24'h699F99, 24'hE9E99E, 24'hE8888E,
    24'hE9999E, 24'hF8E88F, 24'hF8E888, 24'h78B997,
    24'h99F999, 24'hE4444E, 24'h111196, 24'h9ACA99,
    24'h88888F, 24'h9FF999, 24'h9DFB99, 24'h699996,
    24'hE99E88, 24'h6999B7, 24'hE99EA9, 24'h78611E,
    24'hE44444, 24'h999996, 24'h999966, 24'h999FF9,
    24'h996699, 24'h996444, 24'hF1248F, 24'h124421,
    24'h842248, 24'h00F000, 24'h444404, 24'h040040
  };

  typedef struct {
    bit         t;
    logic [5:0] rgb;
    bit         d;
    bit         bz;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  bit             m_act = 0;
  logic [1:0]     m_mode = '0;
  logic [5*N-1:0] m_msg = '0;
  int             m_ticks = 0;

  function automatic bit m_typing(input logic [1:0] md);
    return md == 2'd1 || md == 2'd3;
  endfunction

  function automatic int m_limit();
    if (!m_act) return 0;
    if (m_typing(m_mode)) return (m_ticks / TF < N) ? m_ticks / TF : N;
    return N;
  endfunction

  function automatic bit m_vis();
    int st;
    if (!(m_mode == 2'd2 || m_mode == 2'd3)) return 1;
    st = (m_mode == 2'd3) ? m_ticks - N * TF : m_ticks;
    if (st < 0) return 1;
    return ((st / BF) % 2) == 0;
  endfunction

  function automatic bit m_lit(input int x, input int y, input int lim,
                               input logic [5*N-1:0] mm);
    int k, dx, dy, row, col;
    logic [4:0] c;
    logic [23:0] gl;
    if (x < OX || y < OY) return 0;
    dy = y - OY;
    if (dy >= GH) return 0;
    k  = (x - OX) / P;
    dx = (x - OX) % P;
    if (k >= lim || dx >= GW) return 0;
    c   = mm[5*k +: 5];
    gl  = font[c];
    row = dy / (1 << S);
    col = dx / (1 << S);
    return gl[23 - (4 * row + col)];
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, expv, $time);
    end
  endtask

  task automatic drive(input bit st, input logic [1:0] md,
                       input logic [5*N-1:0] mm, input bit tk,
                       input int x, input int y, input logic [5:0] fg);
    exp_t e;
    bit txt, sh, vis;
    int lim;
    @(negedge clk);
    start = st; mode = md; msg = mm; frame_tick = tk;
    pix_x = 10'(x); pix_y = 10'(y); fg_rgb = fg;
    lim = m_limit();
    vis = m_vis();
    txt = vis && m_lit(x, y, lim, m_msg);
    sh  = 0;
`ifdef TEXT_SHADOW_EN
    sh = vis && !txt && m_lit(x - (1 << S), y - (1 << S), lim, m_msg);
`endif
    e.t   = txt;
    e.rgb = txt ? fg : (sh ? 6'b010101 : 6'b000000);
    e.d   = 0;
    if (st) begin
      m_act = 1; m_mode = md; m_msg = mm; m_ticks = 0;
      e.d = !m_typing(md);
    end else if (tk && m_act) begin
      m_ticks++;
      if (m_typing(m_mode) && m_ticks == N * TF) e.d = 1;
    end
    e.bz = m_act && m_typing(m_mode) && m_ticks < N * TF;
    q.push_back(e);
  endtask

  function automatic logic [5*N-1:0] rmsg();
    logic [5*N-1:0] m;
    for (int i = 0; i < N; i++) m[5*i +: 5] = 5'($urandom_range(0, 31));
    return m;
  endfunction

  task automatic pick(output int x, output int y);
    int k;
    if ($urandom_range(0, 3) != 0) begin
      k = $urandom_range(0, N);
      x = OX + k * P + $urandom_range(0, P - 1);
      y = OY - 10 + $urandom_range(0, 70);
    end else begin
      x = $urandom_range(0, 1023);
      y = $urandom_range(0, 1023);
    end
  endtask

  // Idle cycle: random pixel, inputs mode/msg scrambled (must be ignored).
  task automatic run(input int cycles, input int tick_pct);
    int x, y;
    for (int i = 0; i < cycles; i++) begin
      pick(x, y);
      drive(0, 2'($urandom_range(0, 3)), rmsg(),
            $urandom_range(0, 99) < tick_pct, x, y,
            6'($urandom_range(0, 63)));
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("text_on", int'(text_on), int'(e.t));
        chk("rgb", int'({r, g, b}), int'(e.rgb));
        chk("done", int'(done), int'(e.d));
        chk("busy", int'(busy), int'(e.bz));
      end
    end
  end

  initial begin : driver
    logic [5*N-1:0] m;
    int x, y;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_text_on", int'(text_on), 0);
    chk("rst_rgb", int'({r, g, b}), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk) rst_n = 1'b1;

    run(150, 40);

    m = '0;
    m[4:0] = 5'd3;
    drive(1, 2'd0, m, 0, 0, 0, 6'h3F);
    drive(0, 2'd1, rmsg(), 0, 16, 40, 6'h3F);
    drive(0, 2'd2, rmsg(), 1, 40, 40, 6'h3F);
    drive(0, 2'd3, rmsg(), 0, 50, 40, 6'h3F);
    drive(0, 2'd0, rmsg(), 0, 17 + 8, 40 + 8, 6'h3F);
    drive(1, 2'd0, rmsg(), 0, 16, 40, 6'h3F);
    run(80, 30);

    for (int i = 0; i < N; i++) m[5*i +: 5] = 5'd8;
    drive(1, 2'd1, m, 0, 16, 40, 6'h2A);
    for (int i = 0; i < 400; i++) begin
      x = OX + $urandom_range(0, N) * P + $urandom_range(0, 7);
      y = OY + $urandom_range(0, GH - 1);
      drive(0, 2'($urandom_range(0, 3)), rmsg(),
            $urandom_range(0, 1) == 1, x, y, 6'($urandom_range(0, 63)));
    end

    drive(1, 2'd3, rmsg(), 1, 16, 40, 6'h3F);
    run(450, 75);

    drive(1, 2'd1, rmsg(), 0, 16, 40, 6'h3F);
    for (int i = 0; i < 2000 && m_limit() < 5; i++) begin
      pick(x, y);
      drive(0, 2'($urandom_range(0, 3)), rmsg(), i % 2 == 1, x, y, 6'h3F);
    end
    drive(1, 2'd1, rmsg(), 1, 16, 40, 6'h3F);
    run(100, 50);
    drive(1, 2'd2, rmsg(), 0, 16, 40, 6'h15);
    run(300, 60);

    drive(1, 2'd1, rmsg(), 0, 16, 40, 6'h3F);
    run(40, 50);
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_text_on", int'(text_on), 0);
    chk("midrst_rgb", int'({r, g, b}), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_busy", int'(busy), 0);
    #20;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/text_banner_renderer.md
Name: text_banner_renderer

Overview:
- Parametrised text-overlay renderer for menu and end screens.
- Draws a NUM_CHARS-long message of 5-bit character codes using the team 4x6 font, scaled by 2^SCALE_LOG2, at a fixed origin.
- Supports typewriter reveal, blinking and static modes, driven by a per-frame tick in the pixel-clock domain.
- Sits between the VGA timing generator and the game colour mixer. It outputs a registered pixel-hit flag and colour.

Parameters:
- NUM_CHARS, 17: message length in characters.
- SCALE_LOG2, 3: log2 of screen pixels per font bit (3 gives 8 px, so a glyph is 32x48).
- CHAR_PITCH, 36: horizontal distance between character origins, in pixels. Must be at least 4<<SCALE_LOG2.
- ORIGIN_X, 16: x of character 0.
- ORIGIN_Y, 40: y of all characters.
- TYPE_FRAMES, 9: frames per revealed character in typewriter modes (1..255).
- BLINK_FRAMES, 32: frames per blink half-period (1..255).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  single-cycle pulse, once per frame, at start of vblank.
- pix_x  in  10  current pixel column.
- pix_y  in  10  current pixel row.
- start  in  1  single-cycle pulse; latches msg and mode, restarts animation.
- mode  in  2  0 static, 1 typewriter, 2 blink, 3 typewriter-then-blink.
- msg  in  5*NUM_CHARS  character codes; char k occupies bits [5k+4:5k].
- fg_rgb  in  6  text colour {r,g,b}, 2 bits each.
- text_on  out  1  registered: current pixel is a lit text pixel.
- r, g, b  out  2 each  registered colour: fg_rgb when text_on, else 0.
- done  out  1  single-cycle pulse when reveal completes.
- busy  out  1  high while in TYPING.

Behaviour:
- Reset values: text_on=0, r=g=b=0, done=0, busy=0. Also state=IDLE, char_limit=0, type_cnt=0, blink_cnt=0, blink_phase=1, latched msg=all 0, latched mode=0.
- Code map:
  - 0 = space (never lit).
  - 1..26 = A..Z.
  - 27 '<', 28 '>', 29 '-', 30 '!', 31 ':'.
  - Glyph row r (0..5), column c (0..3) is bit 23-(4r+c) of the 24-bit glyph.
- Hit test:
  - Char k covers x in [ORIGIN_X+k*CHAR_PITCH, +4<<SCALE_LOG2) and y in [ORIGIN_Y, +6<<SCALE_LOG2).
  - Within a char: c=(x-ox)>>SCALE_LOG2 and r=(y-ORIGIN_Y)>>SCALE_LOG2. No dividers.
  - A pixel is lit only if k<char_limit, the glyph bit is set, and visible=1.
  - Gap pixels between chars and pixels outside the box are never lit.
  - All arithmetic is 10-bit unsigned. Positions with ox+width>1023 are not supported.
- Output latency: exactly 1 clk from pix_x/pix_y to text_on/r/g/b.
- State machine, advancing only on frame_tick except start:
  - IDLE: nothing displayed. On start go to TYPING if mode is 1 or 3, else go to SHOW with char_limit=NUM_CHARS.
  - TYPING: busy=1. On each frame_tick, type_cnt++. When type_cnt==TYPE_FRAMES-1, clear type_cnt and increment char_limit. When char_limit reaches NUM_CHARS, pulse done the same cycle and go to SHOW.
  - SHOW: char_limit holds at NUM_CHARS and saturates; it never wraps. In modes 2 and 3, blink_cnt counts frames and blink_phase toggles at BLINK_FRAMES-1.
  - visible = blink_phase in modes 2 and 3, otherwise 1.
- On entry to SHOW, blink_cnt is cleared and blink_phase is set to 1.
- In static mode, done is pulsed one cycle after start.
- start in any state, including mid-TYPING, restarts from char_limit=0 and relatches msg and mode.
- start and frame_tick in the same cycle: start wins, and that tick is ignored.
- msg and mode are ignored except on start, so changes between starts have no effect.
- Reset mid-operation returns immediately to reset values.

Optional Feature:
- Macro: TEXT_SHADOW_EN.
- When defined: each lit glyph pixel also casts a shadow offset by +(1<<SCALE_LOG2) in both x and y.
  - Shadow pixels that are not themselves text output {r,g,b}={01,01,01}, with text_on=0.
  - Text has priority over shadow.
  - Shadow obeys char_limit and visible like text.
- When undefined: no shadow logic; non-text pixels are always 0.

Test Plan:
- Reset, then drive pixels with no start -> text_on=0 and rgb=0 everywhere; busy=0.
- start, mode=0, msg char0=3 ('C'), fg=6'h3F, pixel (16,40) -> text_on=1 and rgb=3/3/3 one clk later. Pixel (40,40), glyph col 3 row 0 = 0 -> text_on=0. Pixel (50,40), in the gap -> text_on=0.
- mode=1, TYPE_FRAMES=9 -> char_limit=1 after 9 ticks; done pulses exactly once after 153 ticks; busy falls the same cycle.
- mode=3 -> after done, visible toggles every 32 ticks (32 frames on, 32 off); char_limit stays at 17.
- start mid-TYPING (char_limit=5), coincident with frame_tick -> char_limit=0 and type_cnt=0; the new msg is displayed.
- TEXT_SHADOW_EN defined, lit pixel at (16,40) -> pixel (24,48) outputs 1/1/1 unless it is itself text.
